// File: rtl/vedic_seq_mult_ctrl_if.sv
// Operand/result handshake bundle for the sequential Vedic multiplier.
// The master drives operands and consumes the product; the slave is the multiplier.
interface vedic_seq_mult_ctrl_if #(
    parameter int unsigned WIDTH = 8
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] product;
    logic               busy;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, product, busy
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, product, busy
    );
endinterface

// File: rtl/vedic_seq_mult_ctrl.sv
// Sequential WIDTHxWIDTH unsigned multiplier: one shared 2x2 Vedic core, one digit pair per
// cycle, partial products shifted and accumulated over N*N cycles (N = WIDTH/2).
module vedic_2x2 (
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic [3:0] p
);
    logic t_lo, t_x0, t_x1, t_hi, c1;

    assign t_lo = a[0] & b[0];
    assign t_x0 = a[1] & b[0];
    assign t_x1 = a[0] & b[1];
    assign t_hi = a[1] & b[1];
    assign c1   = t_x0 & t_x1;

    assign p[0] = t_lo;
    assign p[1] = t_x0 ^ t_x1;
    assign p[2] = t_hi ^ c1;
    assign p[3] = t_hi & c1;
endmodule

module vedic_seq_mult_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    vedic_seq_mult_ctrl_if.slave bus
);
    localparam int unsigned N  = WIDTH / 2;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned SW = $clog2(PW);
    localparam logic [CW-1:0] Last = CW'(N - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e         state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [CW-1:0]  i_q, i_d;
    logic [CW-1:0]  j_q, j_d;
    logic [PW-1:0]  acc_q, acc_d;

    logic [1:0]     a_dig, b_dig;
    logic [3:0]     pp;
    logic [CW:0]    dsum;
    logic [SW-1:0]  shamt;
    logic [PW-1:0]  pp_shifted;

    assign a_dig = a_q[{i_q, 1'b0} +: 2];
    assign b_dig = b_q[{j_q, 1'b0} +: 2];

    vedic_2x2 u_core (
        .a (a_dig),
        .b (b_dig),
        .p (pp)
    );

    // Digit weight is 4^(i+j), i.e. a shift of 2*(i+j); max 2*WIDTH-4 so it always fits.
    assign dsum       = {1'b0, i_q} + {1'b0, j_q};
    assign shamt      = SW'({dsum, 1'b0});
    assign pp_shifted = {{(PW-4){1'b0}}, pp} << shamt;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        i_d     = i_q;
        j_d     = j_q;
        acc_d   = acc_q;
        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    acc_d   = '0;
                    i_d     = '0;
                    j_d     = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                acc_d = acc_q + pp_shifted;
                // j is the inner loop; finishing the last pair hands off to DONE
                if (j_q == Last) begin
                    j_d = '0;
                    if (i_q == Last) begin
                        state_d = StDone;
                    end else begin
                        i_d = i_q + 1'b1;
                    end
                end else begin
                    j_d = j_q + 1'b1;
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            i_q     <= '0;
            j_q     <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            i_q     <= i_d;
            j_q     <= j_d;
            acc_q   <= acc_d;
        end
    end

    assign bus.in_ready  = (state_q == StIdle);
    assign bus.out_valid = (state_q == StDone);
    assign bus.busy      = (state_q == StRun) || (state_q == StDone);
    assign bus.product   = acc_q;
endmodule

// File: tb/tb_vedic_seq_mult_ctrl.sv
// Directed bench for vedic_seq_mult_ctrl: an 8-bit instance for the scenario tests and a
// 4-bit instance for the exhaustive back-to-back sweep.
module tb_vedic_seq_mult_ctrl;
    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;

    vedic_seq_mult_ctrl_if #(.WIDTH(8)) i8 ();
    vedic_seq_mult_ctrl_if #(.WIDTH(4)) i4 ();

    vedic_seq_mult_ctrl #(.WIDTH(8)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (i8)
    );

    vedic_seq_mult_ctrl #(.WIDTH(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (i4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Drives one 8-bit operation with out_ready held high; returns observations only.
    task automatic op8(input logic [7:0] a, input logic [7:0] b, output int lat,
                       output logic [15:0] prod, output int rdy_low,
                       output logic ov_after, output logic rdy_after);
        i8.a         = a;
        i8.b         = b;
        i8.in_valid  = 1'b1;
        i8.out_ready = 1'b1;
        step();
        i8.in_valid = 1'b0;
        lat     = 0;
        rdy_low = 0;
        while (!i8.out_valid && lat < 100) begin
            if (!i8.in_ready) rdy_low++;
            step();
            lat++;
        end
        if (!i8.in_ready) rdy_low++;
        prod = i8.product;
        step();
        ov_after  = i8.out_valid;
        rdy_after = i8.in_ready;
    endtask

    task automatic test_reset;
        rst          = 1'b1;
        i8.in_valid  = 1'b0;
        i8.out_ready = 1'b0;
        i8.a         = '0;
        i8.b         = '0;
        i4.in_valid  = 1'b0;
        i4.out_ready = 1'b0;
        i4.a         = '0;
        i4.b         = '0;
        #2;
        tests_run++;
        if ({i8.in_ready, i8.out_valid, i8.busy} !== 3'b100) begin
            tests_failed++;
            $display("FAIL reset8_flags: got %b expected 100", {i8.in_ready, i8.out_valid, i8.busy});
        end
        tests_run++;
        if (i8.product !== 16'h0000) begin
            tests_failed++;
            $display("FAIL reset8_product: got %h expected 0000", i8.product);
        end
        tests_run++;
        if ({i4.in_ready, i4.out_valid, i4.busy, i4.product} !== {3'b100, 8'h00}) begin
            tests_failed++;
            $display("FAIL reset4_state: got %b/%h expected 100/00",
                     {i4.in_ready, i4.out_valid, i4.busy}, i4.product);
        end
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic;
        int lat, rdy_low;
        logic [15:0] prod;
        logic ov_after, rdy_after;
        op8(8'hA5, 8'h3C, lat, prod, rdy_low, ov_after, rdy_after);
        tests_run++;
        if (prod !== 16'h26AC) begin
            tests_failed++;
            $display("FAIL basic_product: got %h expected 26ac", prod);
        end
        tests_run++;
        if (lat != 16) begin
            tests_failed++;
            $display("FAIL basic_latency: got %0d expected 16", lat);
        end
        tests_run++;
        if (rdy_low != 17) begin
            tests_failed++;
            $display("FAIL basic_in_ready_low: got %0d expected 17", rdy_low);
        end
        tests_run++;
        if ({ov_after, rdy_after} !== 2'b01) begin
            tests_failed++;
            $display("FAIL basic_single_pulse: got ov=%b rdy=%b expected ov=0 rdy=1",
                     ov_after, rdy_after);
        end
    endtask

    task automatic test_corners;
        logic [7:0]  va [3];
        logic [7:0]  vb [3];
        logic [15:0] vp [3];
        int lat, rdy_low;
        logic [15:0] prod;
        logic ov_after, rdy_after;
        va[0] = 8'hFF; vb[0] = 8'hFF; vp[0] = 16'hFE01;
        va[1] = 8'h00; vb[1] = 8'h7B; vp[1] = 16'h0000;
        va[2] = 8'h01; vb[2] = 8'h80; vp[2] = 16'h0080;
        for (int k = 0; k < 3; k++) begin
            op8(va[k], vb[k], lat, prod, rdy_low, ov_after, rdy_after);
            tests_run++;
            if (prod !== vp[k]) begin
                tests_failed++;
                $display("FAIL corner_product_%0d: got %h expected %h", k, prod, vp[k]);
            end
            tests_run++;
            if (lat != 16) begin
                tests_failed++;
                $display("FAIL corner_latency_%0d: got %0d expected 16", k, lat);
            end
        end
    endtask

    task automatic test_backpressure;
        int lat;
        i8.a         = 8'h5A;
        i8.b         = 8'hC3;
        i8.in_valid  = 1'b1;
        i8.out_ready = 1'b0;
        step();
        i8.in_valid = 1'b0;
        lat = 0;
        while (!i8.out_valid && lat < 100) begin
            step();
            lat++;
        end
        tests_run++;
        if (lat != 16) begin
            tests_failed++;
            $display("FAIL bp_latency: got %0d expected 16", lat);
        end
        // new operands offered while DONE is stalled must not be taken
        i8.a        = 8'h11;
        i8.b        = 8'h22;
        i8.in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tests_run++;
            if ({i8.out_valid, i8.in_ready, i8.product} !== {2'b10, 16'h448E}) begin
                tests_failed++;
                $display("FAIL bp_hold_%0d: got ov=%b rdy=%b prod=%h expected ov=1 rdy=0 prod=448e",
                         c, i8.out_valid, i8.in_ready, i8.product);
            end
            step();
        end
        i8.out_ready = 1'b1;
        step();
        tests_run++;
        if ({i8.in_ready, i8.busy, i8.out_valid} !== 3'b100) begin
            tests_failed++;
            $display("FAIL bp_release: got rdy/busy/ov=%b expected 100",
                     {i8.in_ready, i8.busy, i8.out_valid});
        end
        step();
        i8.in_valid = 1'b0;
        tests_run++;
        if (i8.busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_accept_after_ready: got busy=%b expected 1", i8.busy);
        end
        lat = 0;
        while (!i8.out_valid && lat < 100) begin
            step();
            lat++;
        end
        tests_run++;
        if (i8.product !== 16'h0242 || lat != 16) begin
            tests_failed++;
            $display("FAIL bp_next_op: got prod=%h lat=%0d expected prod=0242 lat=16",
                     i8.product, lat);
        end
        step();
    endtask

    task automatic test_reset_midrun;
        int ov_seen, lat, rdy_low;
        logic [15:0] prod;
        logic ov_after, rdy_after;
        i8.a         = 8'hFF;
        i8.b         = 8'hFF;
        i8.in_valid  = 1'b1;
        i8.out_ready = 1'b1;
        step();
        i8.in_valid = 1'b0;
        repeat (6) step();
        tests_run++;
        if (i8.busy !== 1'b1 || i8.product === 16'h0000) begin
            tests_failed++;
            $display("FAIL rst_precondition: got busy=%b prod=%h expected busy=1 prod nonzero",
                     i8.busy, i8.product);
        end
        #2;
        rst = 1'b1;
        #1;
        tests_run++;
        if ({i8.in_ready, i8.out_valid, i8.busy, i8.product} !== {3'b100, 16'h0000}) begin
            tests_failed++;
            $display("FAIL rst_async: got flags=%b prod=%h expected flags=100 prod=0000",
                     {i8.in_ready, i8.out_valid, i8.busy}, i8.product);
        end
        step();
        step();
        rst = 1'b0;
        ov_seen = 0;
        for (int c = 0; c < 20; c++) begin
            if (i8.out_valid) ov_seen++;
            step();
        end
        tests_run++;
        if (ov_seen != 0) begin
            tests_failed++;
            $display("FAIL rst_no_out_valid: got %0d cycles expected 0", ov_seen);
        end
        op8(8'h12, 8'h34, lat, prod, rdy_low, ov_after, rdy_after);
        tests_run++;
        if (prod !== 16'h03A8 || lat != 16) begin
            tests_failed++;
            $display("FAIL rst_followup: got prod=%h lat=%0d expected prod=03a8 lat=16", prod, lat);
        end
    endtask

    task automatic test_sweep4;
        int lat, stall, wait_cnt;
        logic [7:0] exp_p;
        for (int k = 0; k < 256; k++) begin
            exp_p        = 8'((k >> 4) * (k & 15));
            i4.a         = 4'(k >> 4);
            i4.b         = 4'(k & 15);
            i4.in_valid  = 1'b1;
            wait_cnt = 0;
            while (!i4.in_ready && wait_cnt < 20) begin
                step();
                wait_cnt++;
            end
            step();
            i4.in_valid = 1'b0;
            lat = 0;
            while (!i4.out_valid && lat < 20) begin
                i4.out_ready = 1'($urandom_range(0, 1));
                step();
                lat++;
            end
            tests_run++;
            if (lat != 4 || i4.product !== exp_p) begin
                tests_failed++;
                $display("FAIL sweep_%0d: got prod=%h lat=%0d expected prod=%h lat=4",
                         k, i4.product, lat, exp_p);
            end
            stall = $urandom_range(0, 2);
            for (int s = 0; s < stall; s++) begin
                i4.out_ready = 1'b0;
                step();
                tests_run++;
                if (i4.out_valid !== 1'b1 || i4.product !== exp_p) begin
                    tests_failed++;
                    $display("FAIL sweep_stall_%0d: got ov=%b prod=%h expected ov=1 prod=%h",
                             k, i4.out_valid, i4.product, exp_p);
                end
            end
            i4.out_ready = 1'b1;
            step();
            tests_run++;
            if ({i4.out_valid, i4.in_ready} !== 2'b01) begin
                tests_failed++;
                $display("FAIL sweep_pulse_%0d: got ov=%b rdy=%b expected ov=0 rdy=1",
                         k, i4.out_valid, i4.in_ready);
            end
        end
        i4.out_ready = 1'b0;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_basic();
        test_corners();
        test_backpressure();
        test_reset_midrun();
        test_sweep4();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
